// File: rtl/adc_proc_pkg.sv
// Shared types and constants for the ADC averaging / millivolt / BCD pipeline.
package adc_proc_pkg;

    localparam int ADC_W      = 8;
    localparam int MV_W       = 13;
    localparam int BCD_W      = 16;
    localparam int VREF_MV    = 5000;
    localparam int CONV_ITERS = MV_W;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        CONV,
        DONE
    } state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock, MV_W iterations per conversion.
module bin2bcd_seq
    import adc_proc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MV_W-1:0]  bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    localparam int ITER_W = $clog2(CONV_ITERS);

    logic [MV_W-1:0]       bin_q;
    logic [BCD_W-1:0]      bcd_q;
    logic [ITER_W-1:0]     iter_q;
    logic                  active_q;
    logic [BCD_W-1:0]      adj;
    logic [BCD_W+MV_W-1:0] shifted;

    // NOTE: combinational blocks assign a default first so no path leaves a variable unassigned (no latch).
    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    // High during the final iteration so the sequencer can leave CONV on the same edge.
    assign done = active_q && (iter_q == ITER_W'(CONV_ITERS - 1));
    assign bcd  = bcd_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            bin_q    <= bin;
            bcd_q    <= '0;
            iter_q   <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            bcd_q  <= shifted[BCD_W+MV_W-1:MV_W];
            bin_q  <= shifted[MV_W-1:0];
            iter_q <= iter_q + ITER_W'(1);
            if (done) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_avg_bcd.sv
// Box-car averages ADC samples, scales the average to millivolts and emits it in binary and packed BCD.
module adc_avg_bcd
    import adc_proc_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int VREF_MV  = adc_proc_pkg::VREF_MV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] data_in,
    input  logic             data_en,
    output logic [MV_W-1:0]  mv_out,
    output logic [BCD_W-1:0] bcd_out,
    output logic             result_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int ACC_W  = ADC_W + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PROD_W = ADC_W + MV_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, sum;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADC_W-1:0]  avg, avg_q;
    logic [PROD_W-1:0] prod;
    logic [MV_W-1:0]   mv_d, mv_q, mv_out_q;
    logic [BCD_W-1:0]  bcd_out_q, conv_bcd;
    logic              group_done, load_avg, start_conv, load_out, conv_done;
    logic              result_valid_q, overrun_q;

    assign sum        = acc_q + ACC_W'(data_in);
    assign avg        = ADC_W'(sum >> AVG_LOG2);
    assign group_done = data_en && (cnt_q == CNT_LAST);
    assign prod       = PROD_W'(avg_q) * PROD_W'(VREF_MV);
    assign mv_d       = MV_W'(prod >> ADC_W);

    // The accumulator free-runs; a group closes regardless of whether the sequencer can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (data_en) begin
            if (group_done) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (group_done) state_d = MUL;
            MUL:     state_d = CONV;
            CONV:    if (conv_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_avg   = (state_q == IDLE) && group_done;
        start_conv = (state_q == MUL);
        load_out   = (state_q == DONE);
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_q          <= '0;
            mv_q           <= '0;
            mv_out_q       <= '0;
            bcd_out_q      <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            if (load_avg) avg_q <= avg;
            if (start_conv) mv_q <= mv_d;
            if (load_out) begin
                mv_out_q  <= mv_q;
                bcd_out_q <= conv_bcd;
            end
            result_valid_q <= load_out;
            overrun_q      <= group_done && (state_q != IDLE);
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_conv),
        .bin   (mv_d),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    assign mv_out       = mv_out_q;
    assign bcd_out      = bcd_out_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_avg_bcd.sv
// Directed bench: an 8-sample averager and a single-sample instance for overrun behaviour.
module tb_adc_avg_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  d3 = '0, d0 = '0;
    logic        en3 = 1'b0, en0 = 1'b0;
    logic [12:0] mv3, mv0;
    logic [15:0] bcd3, bcd0;
    logic        rv3, rv0, busy3, busy0, ov3, ov0;

    int checks = 0;
    int errors = 0;
    int rv3_cnt = 0;
    int ov3_cnt = 0;

    adc_avg_bcd #(.AVG_LOG2(3), .VREF_MV(5000)) u3 (
        .clk(clk), .rst_n(rst_n), .data_in(d3), .data_en(en3),
        .mv_out(mv3), .bcd_out(bcd3), .result_valid(rv3), .busy(busy3), .overrun(ov3)
    );

    adc_avg_bcd #(.AVG_LOG2(0), .VREF_MV(5000)) u0 (
        .clk(clk), .rst_n(rst_n), .data_in(d0), .data_en(en0),
        .mv_out(mv0), .bcd_out(bcd0), .result_valid(rv0), .busy(busy0), .overrun(ov0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rv3 === 1'b1) rv3_cnt++;
        if (ov3 === 1'b1) ov3_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int mv);
        return {4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
    endfunction

    task automatic send3(input logic [7:0] v);
        @(negedge clk);
        en3 = 1'b1;
        d3  = v;
    endtask

    // Waits after the last strobe of a group; lat counts clock edges from the accepting edge T.
    task automatic wait_result3(output int lat, output int busy_cycles);
        int k;
        lat = -1;
        busy_cycles = 0;
        k = 0;
        while (lat < 0 && k < 40) begin
            @(negedge clk);
            en3 = 1'b0;
            k++;
            if (busy3 === 1'b1) busy_cycles++;
            if (rv3 === 1'b1) lat = k - 1;
        end
    endtask

    task automatic check_result3(input string tag, input int exp_mv, input logic [15:0] exp_bcd);
        int lat, bc;
        wait_result3(lat, bc);
        check({tag, "_latency"}, 32'(lat), 32'd15);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd15);
        check({tag, "_mv"}, 32'(mv3), 32'(exp_mv));
        check({tag, "_bcd"}, 32'(bcd3), 32'(exp_bcd));
        @(negedge clk);
        check({tag, "_rv_one_cycle"}, 32'(rv3), 32'd0);
        check({tag, "_mv_hold"}, 32'(mv3), 32'(exp_mv));
    endtask

    initial begin
        int base_rv, base_ov, ovc, bc, lat0, sum;
        logic [12:0] mv0s;
        logic [15:0] bcd0s;
        logic [7:0]  v;

        repeat (3) @(negedge clk);
        check("rst_mv3", 32'(mv3), 32'd0);
        check("rst_bcd3", 32'(bcd3), 32'd0);
        check("rst_rv3", 32'(rv3), 32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_ov3", 32'(ov3), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        repeat (8) send3(8'hFF);
        check_result3("full_scale", 4980, 16'h4980);
        repeat (3) @(negedge clk);

        repeat (8) send3(8'h80);
        check_result3("mid_scale", 2500, 16'h2500);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) send3(8'(i));
        check_result3("ramp", 58, 16'h0058);
        repeat (3) @(negedge clk);

        // Reset mid-conversion, with three stray samples sitting in the accumulator.
        repeat (8) send3(8'hFF);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            d3 = 8'h00;
        end
        @(negedge clk);
        en3 = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_conv_busy", 32'(busy3), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        base_rv = rv3_cnt;
        check("rst_mid_mv", 32'(mv3), 32'd0);
        check("rst_mid_bcd", 32'(bcd3), 32'd0);
        check("rst_mid_rv", 32'(rv3), 32'd0);
        check("rst_mid_busy", 32'(busy3), 32'd0);
        check("rst_mid_ov", 32'(ov3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("rst_no_result", 32'(rv3_cnt - base_rv), 32'd0);
        repeat (8) send3(8'h40);
        check_result3("after_reset", 1250, 16'h1250);
        repeat (3) @(negedge clk);

        repeat (8) send3(8'h00);
        check_result3("zeros", 0, 16'h0000);
        repeat (3) @(negedge clk);

        // Three back-to-back single-sample groups: first converts, the next two are dropped.
        @(negedge clk);
        en0 = 1'b1;
        d0  = 8'h10;
        ovc = 0;
        bc = 0;
        lat0 = -1;
        mv0s = '0;
        bcd0s = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) d0 = 8'h20;
            else if (k == 2) d0 = 8'h30;
            else en0 = 1'b0;
            if (ov0 === 1'b1) ovc++;
            if (busy0 === 1'b1) bc++;
            if (rv0 === 1'b1 && lat0 < 0) begin
                lat0  = k - 1;
                mv0s  = mv0;
                bcd0s = bcd0;
            end
        end
        check("ovr_latency", 32'(lat0), 32'd15);
        check("ovr_mv", 32'(mv0s), 32'd312);
        check("ovr_bcd", 32'(bcd0s), 32'h0312);
        check("ovr_pulses", 32'(ovc), 32'd2);
        check("ovr_busy_cycles", 32'(bc), 32'd15);

        // Spaced strobes with random data against an arithmetic reference.
        #1;
        base_ov = ov3_cnt;
        for (int g = 0; g < 2; g++) begin
            sum = 0;
            for (int i = 0; i < 8; i++) begin
                v = 8'($urandom_range(0, 255));
                send3(v);
                sum += int'(v);
                if (i < 7) begin
                    @(negedge clk);
                    en3 = 1'b0;
                    repeat (28) @(negedge clk);
                end
            end
            check_result3("random", ((sum >> 3) * 5000) >> 8, to_bcd(((sum >> 3) * 5000) >> 8));
            repeat (10) @(negedge clk);
        end
        #1;
        check("random_no_overrun", 32'(ov3_cnt - base_ov), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
